// File: rtl/hangman_keypad_pkg.sv
// -----------------------------------------------------------------------------
// hangman_keypad_pkg
// Shared definitions for the keypad-to-letter path of the Hangman front end:
// keypad codes ({row_onehot[7:4], col_onehot[3:0]}), the multi-tap FSM state
// type, the ASCII base letter and a helper that classifies letter keys.
// -----------------------------------------------------------------------------
package hangman_keypad_pkg;

  // Letter keys (phone layout: 2=ABC ... 9=WXYZ)
  localparam logic [7:0] KEY_2    = 8'h84;
  localparam logic [7:0] KEY_3    = 8'h82;
  localparam logic [7:0] KEY_4    = 8'h48;
  localparam logic [7:0] KEY_5    = 8'h44;
  localparam logic [7:0] KEY_6    = 8'h42;
  localparam logic [7:0] KEY_7    = 8'h28;
  localparam logic [7:0] KEY_8    = 8'h24;
  localparam logic [7:0] KEY_9    = 8'h22;

  // Control keys
  localparam logic [7:0] KEY_STAR = 8'h18;  // clear pending letter
  localparam logic [7:0] KEY_HASH = 8'h12;  // commit pending letter

  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_TAPPING = 1'b1
  } multitap_state_t;

  function automatic logic is_letter_key(input logic [7:0] key);
    case (key)
      KEY_2, KEY_3, KEY_4, KEY_5,
      KEY_6, KEY_7, KEY_8, KEY_9: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multitap_decode.sv
// -----------------------------------------------------------------------------
// multitap_decode
// Combinational map from a letter-key code and tap index to an uppercase
// ASCII letter, plus the size of that key's letter group (3, or 4 for 7/9).
// Non-letter codes decode as group 'A'..'C'; callers only present letter keys.
//
// Ports
//   digit       in  8  letter-key code
//   tap_count   in  2  tap index within the group
//   letter      out 8  ASCII letter
//   group_size  out 3  number of letters on this key
// -----------------------------------------------------------------------------
module multitap_decode
  import hangman_keypad_pkg::*;
(
  input  logic [7:0] digit,
  input  logic [1:0] tap_count,
  output logic [7:0] letter,
  output logic [2:0] group_size
);

  logic [4:0] base;

  // NOTE: every output of a combinational block gets a default before the
  // case statement so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    base       = 5'd0;
    group_size = 3'd3;
    case (digit)
      KEY_2: base = 5'd0;
      KEY_3: base = 5'd3;
      KEY_4: base = 5'd6;
      KEY_5: base = 5'd9;
      KEY_6: base = 5'd12;
      KEY_7: begin base = 5'd15; group_size = 3'd4; end
      KEY_8: base = 5'd19;
      KEY_9: begin base = 5'd22; group_size = 3'd4; end
      default: ;
    endcase
  end

  assign letter = ASCII_A + {3'b000, base} + {6'b000000, tap_count};

endmodule

// File: rtl/multitap_letter_fsm.sv
// -----------------------------------------------------------------------------
// multitap_letter_fsm
// Phone-style multi-tap letter entry. Repeated presses of one key cycle
// through its letters; a different letter key, '#', or (optionally) an idle
// timeout commits the pending letter into a one-entry valid/ready buffer.
// '*' discards the pending letter.
//
// Build option
//   MULTITAP_TIMEOUT_EN  defined: idle timer with auto-commit after
//                        TIMEOUT_CYCLES. Undefined: no timer; a pending letter
//                        waits indefinitely for '#' or another letter key.
//
// Ports
//   clk            in  1  system clock
//   nRst           in  1  asynchronous active-low reset
//   cur_key        in  8  keypad code, 0 = no key
//   strobe         in  1  one-cycle key-press event
//   letter_ready   in  1  downstream accepts letter
//   letter         out 8  committed ASCII letter
//   letter_valid   out 1  output buffer full
//   pending_letter out 8  letter being tapped, 0 when idle
//   tap_count      out 2  tap index within current key's group
//   overrun        out 1  pulse: commit refused, buffer full
// -----------------------------------------------------------------------------
module multitap_letter_fsm
  import hangman_keypad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [7:0] cur_key,
  input  logic       strobe,
  input  logic       letter_ready,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic [7:0] pending_letter,
  output logic [1:0] tap_count,
  output logic       overrun
);

  multitap_state_t state, state_next;
  logic [7:0] digit, digit_next;
  logic [7:0] last_key;
  logic [7:0] event_key;
  logic [7:0] decoded;
  logic [2:0] group_size;
  logic [1:0] tap_next;
  logic       tap_wrap;
  logic       out_free;
  logic       commit;
  logic       overrun_next;
  logic       timer_clear;
  logic       timeout_hit;

  multitap_decode u_decode (
    .digit      (digit),
    .tap_count  (tap_count),
    .letter     (decoded),
    .group_size (group_size)
  );

  // A strobe with cur_key already released falls back to the last seen key.
  assign event_key      = (cur_key != 8'h00) ? cur_key : last_key;
  assign out_free       = !letter_valid || letter_ready;
  assign tap_wrap       = ({1'b0, tap_count} == (group_size - 3'd1));
  assign pending_letter = (state == ST_TAPPING) ? decoded : 8'h00;

`ifdef MULTITAP_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer;

  // Counts idle cycles in TAPPING and saturates at TIMER_LAST so a stalled
  // commit fires on the first cycle the output buffer frees up.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      timer <= '0;
    end else if (timer_clear || state_next == ST_IDLE) begin
      timer <= '0;
    end else if (timer != TIMER_LAST) begin
      timer <= timer + TIMER_W'(1);
    end
  end

  assign timeout_hit = (state == ST_TAPPING) && (timer == TIMER_LAST);
`else
  logic unused_timer_inputs;
  assign unused_timer_inputs = timer_clear ^ (^TIMEOUT_CYCLES);
  assign timeout_hit         = 1'b0;
`endif

  // Key events outrank the timeout; an ignored key falls through to it.
  always_comb begin
    state_next   = state;
    digit_next   = digit;
    tap_next     = tap_count;
    commit       = 1'b0;
    overrun_next = 1'b0;
    timer_clear  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe && is_letter_key(event_key)) begin
          state_next  = ST_TAPPING;
          digit_next  = event_key;
          tap_next    = 2'd0;
          timer_clear = 1'b1;
        end
      end
      ST_TAPPING: begin
        if (strobe && event_key == digit) begin
          tap_next    = tap_wrap ? 2'd0 : tap_count + 2'd1;
          timer_clear = 1'b1;
        end else if (strobe && is_letter_key(event_key)) begin
          if (out_free) begin
            commit      = 1'b1;
            digit_next  = event_key;
            tap_next    = 2'd0;
            timer_clear = 1'b1;
          end else begin
            overrun_next = 1'b1;
          end
        end else if (strobe && event_key == KEY_HASH) begin
          if (out_free) begin
            commit     = 1'b1;
            state_next = ST_IDLE;
            tap_next   = 2'd0;
          end else begin
            overrun_next = 1'b1;
          end
        end else if (strobe && event_key == KEY_STAR) begin
          state_next = ST_IDLE;
          tap_next   = 2'd0;
        end else if (timeout_hit && out_free) begin
          commit     = 1'b1;
          state_next = ST_IDLE;
          tap_next   = 2'd0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= ST_IDLE;
      digit     <= 8'h00;
      tap_count <= 2'd0;
      last_key  <= 8'h00;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      digit     <= digit_next;
      tap_count <= tap_next;
      overrun   <= overrun_next;
      if (cur_key != 8'h00) begin
        last_key <= cur_key;
      end
    end
  end

  // One-entry output buffer; a same-cycle commit wins over the accept.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      letter       <= 8'h00;
      letter_valid <= 1'b0;
    end else if (commit) begin
      letter       <= decoded;
      letter_valid <= 1'b1;
    end else if (letter_ready) begin
      letter_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multitap_letter_fsm.sv
// -----------------------------------------------------------------------------
// tb_multitap_letter_fsm
// Directed bench for multitap_letter_fsm with TIMEOUT_CYCLES = 16. Inputs
// change on the falling edge; outputs are sampled on the falling edge, i.e.
// half a cycle after the rising edge that updated them. Works with and
// without MULTITAP_TIMEOUT_EN defined.
// -----------------------------------------------------------------------------
module tb_multitap_letter_fsm;

  localparam logic [7:0] K2 = 8'h84, K3 = 8'h82, K4 = 8'h48, K5 = 8'h44;
  localparam logic [7:0] K6 = 8'h42, K7 = 8'h28, K8 = 8'h24;
  localparam logic [7:0] KSTAR = 8'h18, KHASH = 8'h12;

  logic       clk = 1'b0;
  logic       nRst;
  logic [7:0] cur_key;
  logic       strobe;
  logic       letter_ready;
  logic [7:0] letter;
  logic       letter_valid;
  logic [7:0] pending_letter;
  logic [1:0] tap_count;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] wrap_exp [5] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h50};
  logic [1:0] wrap_tap [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] b2b_key  [4] = '{K3, K4, K5, KHASH};
  logic [7:0] b2b_exp  [4] = '{8'h41, 8'h44, 8'h47, 8'h4A};

  multitap_letter_fsm #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .nRst           (nRst),
    .cur_key        (cur_key),
    .strobe         (strobe),
    .letter_ready   (letter_ready),
    .letter         (letter),
    .letter_valid   (letter_valid),
    .pending_letter (pending_letter),
    .tap_count      (tap_count),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  // Called on a falling edge: strobe is seen by exactly one rising edge and
  // the task returns on the next falling edge with the updated outputs.
  task automatic press(input logic [7:0] key);
    cur_key = key;
    strobe  = 1'b1;
    @(negedge clk);
    cur_key = 8'h00;
    strobe  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    nRst = 1'b0; cur_key = 8'h00; strobe = 1'b0; letter_ready = 1'b0;
    idle(2);
    checks++; if ({letter, letter_valid, pending_letter, tap_count, overrun} !== 20'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {letter, letter_valid, pending_letter, tap_count, overrun}); end
    nRst = 1'b1;
    idle(1);
  endtask

  task automatic test_repeat_tap;
    letter_ready = 1'b1;
    press(K2);
    checks++; if (pending_letter !== 8'h41 || tap_count !== 2'd0) begin errors++; $display("FAIL rpt_first: got %h/%0d want 41/0", pending_letter, tap_count); end
    press(K2);
    checks++; if (pending_letter !== 8'h42 || tap_count !== 2'd1) begin errors++; $display("FAIL rpt_second: got %h/%0d want 42/1", pending_letter, tap_count); end
    press(KHASH);
    checks++; if ({letter_valid, letter, pending_letter} !== {1'b1, 8'h42, 8'h00}) begin errors++; $display("FAIL rpt_commit: got v=%b l=%h p=%h want v=1 l=42 p=00", letter_valid, letter, pending_letter); end
    idle(1);
    checks++; if (letter_valid !== 1'b0) begin errors++; $display("FAIL rpt_one_cycle: got valid=%b want 0", letter_valid); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 5; i++) begin
      press(K7);
      checks++; if (pending_letter !== wrap_exp[i] || tap_count !== wrap_tap[i]) begin errors++; $display("FAIL wrap_tap%0d: got %h/%0d want %h/%0d", i, pending_letter, tap_count, wrap_exp[i], wrap_tap[i]); end
    end
    press(KHASH);
    checks++; if ({letter_valid, letter} !== {1'b1, 8'h50}) begin errors++; $display("FAIL wrap_commit: got v=%b l=%h want v=1 l=50", letter_valid, letter); end
    idle(1);
  endtask

  task automatic test_digit_change;
    press(K4);
    press(K5);
    checks++; if ({letter_valid, letter} !== {1'b1, 8'h47}) begin errors++; $display("FAIL chg_commit: got v=%b l=%h want v=1 l=47", letter_valid, letter); end
    checks++; if (pending_letter !== 8'h4A || tap_count !== 2'd0) begin errors++; $display("FAIL chg_pending: got %h/%0d want 4a/0", pending_letter, tap_count); end
    press(KSTAR);
    checks++; if (letter_valid !== 1'b0 || pending_letter !== 8'h00) begin errors++; $display("FAIL chg_clear: got v=%b p=%h want v=0 p=00", letter_valid, pending_letter); end
  endtask

  task automatic test_key_capture;
    press(K2);
    press(8'h00);  // released key: event taken from last_key
    checks++; if (pending_letter !== 8'h42 || tap_count !== 2'd1) begin errors++; $display("FAIL cap_last_key: got %h/%0d want 42/1", pending_letter, tap_count); end
    press(8'h11);  // not a defined key
    press(8'h00);  // last_key is now the ignored code
    checks++; if (pending_letter !== 8'h42 || tap_count !== 2'd1 || letter_valid !== 1'b0) begin errors++; $display("FAIL cap_ignored: got %h/%0d v=%b want 42/1 v=0", pending_letter, tap_count, letter_valid); end
    press(KSTAR);
  endtask

  task automatic test_back_to_back;
    letter_ready = 1'b1;
    press(K2);
    for (int i = 0; i < 4; i++) begin
      press(b2b_key[i]);
      checks++; if ({letter_valid, letter} !== {1'b1, b2b_exp[i]}) begin errors++; $display("FAIL b2b_%0d: got v=%b l=%h want v=1 l=%h", i, letter_valid, letter, b2b_exp[i]); end
    end
    idle(1);
    checks++; if (letter_valid !== 1'b0 || pending_letter !== 8'h00) begin errors++; $display("FAIL b2b_drain: got v=%b p=%h want v=0 p=00", letter_valid, pending_letter); end
  endtask

  task automatic test_timeout;
    int n;
    letter_ready = 1'b1;
`ifdef MULTITAP_TIMEOUT_EN
    press(K3);
    n = 0;
    while (!letter_valid && n < 40) begin @(negedge clk); n++; end
    checks++; if (n + 1 !== 17 || letter !== 8'h44) begin errors++; $display("FAIL to_latency: got %0d cycles l=%h want 17 cycles l=44", n + 1, letter); end
    idle(1);
    checks++; if (letter_valid !== 1'b0 || pending_letter !== 8'h00) begin errors++; $display("FAIL to_idle: got v=%b p=%h want v=0 p=00", letter_valid, pending_letter); end
`else
    press(K3);
    idle(40);
    checks++; if (letter_valid !== 1'b0 || pending_letter !== 8'h44) begin errors++; $display("FAIL noto_persist: got v=%b p=%h want v=0 p=44", letter_valid, pending_letter); end
    press(KHASH);
    checks++; if ({letter_valid, letter} !== {1'b1, 8'h44}) begin errors++; $display("FAIL noto_commit: got v=%b l=%h want v=1 l=44", letter_valid, letter); end
    idle(1);
`endif
    // Stalled output: D sits in the buffer while new entry overruns.
    letter_ready = 1'b0;
    press(K3);
`ifdef MULTITAP_TIMEOUT_EN
    n = 0;
    while (!letter_valid && n < 40) begin @(negedge clk); n++; end
`else
    press(KHASH);
`endif
    checks++; if ({letter_valid, letter} !== {1'b1, 8'h44}) begin errors++; $display("FAIL stall_commit: got v=%b l=%h want v=1 l=44", letter_valid, letter); end
    press(K5);
    checks++; if (pending_letter !== 8'h4A || overrun !== 1'b0) begin errors++; $display("FAIL stall_entry: got p=%h ovr=%b want p=4a ovr=0", pending_letter, overrun); end
    press(KHASH);
    checks++; if (overrun !== 1'b1 || pending_letter !== 8'h4A || letter !== 8'h44) begin errors++; $display("FAIL stall_hash_ovr: got ovr=%b p=%h l=%h want ovr=1 p=4a l=44", overrun, pending_letter, letter); end
    press(K6);
    checks++; if (overrun !== 1'b1 || pending_letter !== 8'h4A) begin errors++; $display("FAIL stall_key_ovr: got ovr=%b p=%h want ovr=1 p=4a", overrun, pending_letter); end
    idle(20);
    checks++; if ({letter_valid, letter, pending_letter, overrun} !== {1'b1, 8'h44, 8'h4A, 1'b0}) begin errors++; $display("FAIL stall_hold: got v=%b l=%h p=%h ovr=%b want v=1 l=44 p=4a ovr=0", letter_valid, letter, pending_letter, overrun); end
    letter_ready = 1'b1;
    press(KHASH);  // accept and commit in the same cycle
    checks++; if ({letter_valid, letter, pending_letter} !== {1'b1, 8'h4A, 8'h00}) begin errors++; $display("FAIL stall_release: got v=%b l=%h p=%h want v=1 l=4a p=00", letter_valid, letter, pending_letter); end
    idle(1);
    checks++; if (letter_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got v=%b want 0", letter_valid); end
  endtask

  task automatic test_clear;
    letter_ready = 1'b1;
    press(K6);
    checks++; if (pending_letter !== 8'h4D) begin errors++; $display("FAIL clr_pending: got %h want 4d", pending_letter); end
    press(KSTAR);
    checks++; if ({letter_valid, pending_letter, tap_count} !== {1'b0, 8'h00, 2'd0}) begin errors++; $display("FAIL clr_idle: got v=%b p=%h t=%0d want v=0 p=00 t=0", letter_valid, pending_letter, tap_count); end
    idle(1);
    checks++; if (letter_valid !== 1'b0) begin errors++; $display("FAIL clr_no_commit: got v=%b want 0", letter_valid); end
  endtask

  task automatic test_reset_mid;
    letter_ready = 1'b0;
    press(K2);
    press(KHASH);
    press(K8);
    checks++; if ({letter_valid, letter, pending_letter} !== {1'b1, 8'h41, 8'h54}) begin errors++; $display("FAIL rst_setup: got v=%b l=%h p=%h want v=1 l=41 p=54", letter_valid, letter, pending_letter); end
    #2 nRst = 1'b0;
    #1;
    checks++; if ({letter, letter_valid, pending_letter, tap_count, overrun} !== 20'h0) begin errors++; $display("FAIL rst_async: got %h want 0", {letter, letter_valid, pending_letter, tap_count, overrun}); end
    @(negedge clk);
    nRst = 1'b1;
    letter_ready = 1'b1;
    @(negedge clk);
    press(KHASH);  // nothing pending after reset
    checks++; if (letter_valid !== 1'b0 || pending_letter !== 8'h00) begin errors++; $display("FAIL rst_discard: got v=%b p=%h want v=0 p=00", letter_valid, pending_letter); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_repeat_tap;
    test_wrap;
    test_digit_change;
    test_key_capture;
    test_back_to_back;
    test_timeout;
    test_clear;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
